// File: rtl/led_pattern_gen.sv
// Multi-channel indicator driver: off/on/repeat/one-shot bit patterns
// stepped from a shared free-running prescaler.
module led_pattern_gen #(
   parameter int                      CHANNELS       = 2,
   parameter int                      PRESCALE       = 40000,
   parameter int                      PATTERN_BITS   = 8,
   parameter logic [PATTERN_BITS-1:0] RESET_PATTERN0 = PATTERN_BITS'(8'b00001111),
   parameter logic [7:0]              RESET_RATE0    = 8'd24
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        write,
   input  logic [$clog2(CHANNELS)-1:0] chan_sel,
   input  logic [1:0]                  mode,
   input  logic [PATTERN_BITS-1:0]     pattern,
   input  logic [7:0]                  rate,
   output logic [CHANNELS-1:0]         out,
   output logic [CHANNELS-1:0]         done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (PATTERN_BITS > 1) ? $clog2(PATTERN_BITS) : 1;
   localparam logic [PW-1:0] PS_MAX  = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(PATTERN_BITS - 1);

   typedef enum logic [1:0] {
      M_OFF     = 2'b00,
      M_ON      = 2'b01,
      M_REPEAT  = 2'b10,
      M_ONESHOT = 2'b11
   } mode_e;

   logic [PW-1:0]           pcnt;
   logic                    tick;
   mode_e                   mode_r    [CHANNELS];
   logic [PATTERN_BITS-1:0] pattern_r [CHANNELS];
   logic [7:0]              rate_r    [CHANNELS];
   logic [7:0]              rcnt      [CHANNELS];
   logic [IW-1:0]           idx       [CHANNELS];
   logic [CHANNELS-1:0]     wr_hit;
   logic [CHANNELS-1:0]     run;
   logic [CHANNELS-1:0]     fire;
   logic [CHANNELS-1:0]     out_d;

   assign tick = (pcnt == PS_MAX);

   // Phase is global and never realigned by a write.
   always_ff @(posedge clock) begin
      if (reset)
         pcnt <= '0;
      else if (tick)
         pcnt <= '0;
      else
         pcnt <= pcnt + 1'b1;
   end

   always_comb begin
      wr_hit = '0;
      run    = '0;
      fire   = '0;
      out_d  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         wr_hit[c] = write && (int'(chan_sel) == c);
         run[c]    = tick && ((mode_r[c] == M_REPEAT) ||
                              ((mode_r[c] == M_ONESHOT) && !done[c]));
         fire[c]   = run[c] && (rcnt[c] == rate_r[c]);
         unique case (mode_r[c])
            M_OFF:     out_d[c] = 1'b0;
            M_ON:      out_d[c] = 1'b1;
            M_REPEAT:  out_d[c] = pattern_r[c][idx[c]];
            M_ONESHOT: out_d[c] = !done[c] && pattern_r[c][idx[c]];
         endcase
      end
   end

   // A write to a channel overrides any step landing in the same cycle.
   always_ff @(posedge clock) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (reset) begin
            mode_r[c]    <= (c == 0) ? M_REPEAT : M_OFF;
            pattern_r[c] <= (c == 0) ? RESET_PATTERN0 : '0;
            rate_r[c]    <= (c == 0) ? RESET_RATE0 : '0;
            rcnt[c]      <= '0;
            idx[c]       <= '0;
            done[c]      <= 1'b0;
         end else if (wr_hit[c]) begin
            mode_r[c]    <= mode_e'(mode);
            pattern_r[c] <= pattern;
            rate_r[c]    <= rate;
            rcnt[c]      <= '0;
            idx[c]       <= '0;
            done[c]      <= 1'b0;
         end else if (run[c]) begin
            if (fire[c]) begin
               rcnt[c] <= '0;
               if (idx[c] == IDX_MAX) begin
                  idx[c] <= '0;
                  if (mode_r[c] == M_ONESHOT)
                     done[c] <= 1'b1;
               end else begin
                  idx[c] <= idx[c] + 1'b1;
               end
            end else begin
               rcnt[c] <= rcnt[c] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         out <= '0;
      else
         out <= out_d;
   end

endmodule
